// File: rtl/fcmp_axis.sv
// fcmp_axis: AXI-Stream single-precision compare (EQ / LE / LT selected by OP).
// Each operand channel has a one-entry holding slot. When both slots are full,
// the pair issues into a LATENCY-deep pipeline that stalls on result backpressure.
module fcmp_axis #(
    parameter int unsigned OP      = 0,
    parameter int unsigned LATENCY = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] s_axis_a_tdata,
    input  logic        s_axis_a_tvalid,
    output logic        s_axis_a_tready,
    input  logic [31:0] s_axis_b_tdata,
    input  logic        s_axis_b_tvalid,
    output logic        s_axis_b_tready,
    output logic [7:0]  m_axis_result_tdata,
    output logic        m_axis_result_tvalid,
    input  logic        m_axis_result_tready
);

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 8;

    logic [DW-1:0]      a_q, a_d;
    logic [DW-1:0]      b_q, b_d;
    logic               full_a_q, full_a_d;
    logic               full_b_q, full_b_d;
    logic [LATENCY:1]   vld_q, vld_d;
    logic [LATENCY:1]   res_q, res_d;

    logic               advance_c;
    logic               issue_c;
    logic               a_nan_c, b_nan_c, both_zero_c;
    logic               eq_c, lt_c, cmp_c;

    // Slot readiness comes straight from the full flags.
    assign s_axis_a_tready      = !full_a_q;
    assign s_axis_b_tready      = !full_b_q;
    assign m_axis_result_tvalid = vld_q[LATENCY];
    assign m_axis_result_tdata  = RW'(res_q[LATENCY]);

    // Compare the held operands: NaN yields false, +0 and -0 are equal, otherwise sign-magnitude order.
    always_comb begin
        a_nan_c     = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan_c     = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
        both_zero_c = (a_q[30:0] == 31'd0) && (b_q[30:0] == 31'd0);
        eq_c        = (a_q == b_q) || both_zero_c;
        if (a_q[31] != b_q[31]) begin
            lt_c = a_q[31] && !both_zero_c;
        end else if (a_q[31]) begin
            lt_c = a_q[30:0] > b_q[30:0];
        end else begin
            lt_c = a_q[30:0] < b_q[30:0];
        end
        if (OP == 0) begin
            cmp_c = eq_c;
        end else if (OP == 1) begin
            cmp_c = eq_c || lt_c;
        end else begin
            cmp_c = lt_c;
        end
        if (a_nan_c || b_nan_c) begin
            cmp_c = 1'b0;
        end
    end

    // Next state for the holding slots and the pipeline stages.
    always_comb begin
        advance_c = !(vld_q[LATENCY] && !m_axis_result_tready);
        issue_c   = full_a_q && full_b_q && advance_c;
        a_d       = a_q;
        b_d       = b_q;
        full_a_d  = full_a_q;
        full_b_d  = full_b_q;
        vld_d     = vld_q;
        res_d     = res_q;

        if (issue_c) begin
            full_a_d = 1'b0;
        end else if (!full_a_q && s_axis_a_tvalid) begin
            full_a_d = 1'b1;
            a_d      = s_axis_a_tdata;
        end

        if (issue_c) begin
            full_b_d = 1'b0;
        end else if (!full_b_q && s_axis_b_tvalid) begin
            full_b_d = 1'b1;
            b_d      = s_axis_b_tdata;
        end

        if (advance_c) begin
            vld_d[1] = issue_c;
            res_d[1] = issue_c && cmp_c;
            for (int i = 2; i <= int'(LATENCY); i++) begin
                vld_d[i] = vld_q[i-1];
                res_d[i] = res_q[i-1];
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            full_a_q <= 1'b0;
            full_b_q <= 1'b0;
            vld_q    <= '0;
            res_q    <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            full_a_q <= full_a_d;
            full_b_q <= full_b_d;
            vld_q    <= vld_d;
            res_q    <= res_d;
        end
    end

endmodule

// File: tb/tb_fcmp_axis.sv
// tb_fcmp_axis: three instances (EQ, LE, LT) share the input streams.
// The reference model orders floats by mapping each operand to a signed integer key.
module tb_fcmp_axis;

    localparam int unsigned LAT = 2;

    logic        CLK;
    logic        reset;
    logic [31:0] a_data, b_data;
    logic        a_valid, b_valid, m_ready;
    logic        a_rdy_eq, a_rdy_le, a_rdy_lt;
    logic        b_rdy_eq, b_rdy_le, b_rdy_lt;
    logic [7:0]  d_eq, d_le, d_lt;
    logic        v_eq, v_le, v_lt;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [23:0] exp_q[$];
    logic        hold_v = 1'b0;
    logic [23:0] hold_d = '0;

    fcmp_axis #(.OP(0), .LATENCY(LAT)) dut_eq (
        .CLK(CLK), .reset(reset),
        .s_axis_a_tdata(a_data), .s_axis_a_tvalid(a_valid), .s_axis_a_tready(a_rdy_eq),
        .s_axis_b_tdata(b_data), .s_axis_b_tvalid(b_valid), .s_axis_b_tready(b_rdy_eq),
        .m_axis_result_tdata(d_eq), .m_axis_result_tvalid(v_eq), .m_axis_result_tready(m_ready));
    fcmp_axis #(.OP(1), .LATENCY(LAT)) dut_le (
        .CLK(CLK), .reset(reset),
        .s_axis_a_tdata(a_data), .s_axis_a_tvalid(a_valid), .s_axis_a_tready(a_rdy_le),
        .s_axis_b_tdata(b_data), .s_axis_b_tvalid(b_valid), .s_axis_b_tready(b_rdy_le),
        .m_axis_result_tdata(d_le), .m_axis_result_tvalid(v_le), .m_axis_result_tready(m_ready));
    fcmp_axis #(.OP(2), .LATENCY(LAT)) dut_lt (
        .CLK(CLK), .reset(reset),
        .s_axis_a_tdata(a_data), .s_axis_a_tvalid(a_valid), .s_axis_a_tready(a_rdy_lt),
        .s_axis_b_tdata(b_data), .s_axis_b_tvalid(b_valid), .s_axis_b_tready(b_rdy_lt),
        .m_axis_result_tdata(d_lt), .m_axis_result_tvalid(v_lt), .m_axis_result_tready(m_ready));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [23:0] obs_vec();
        return {d_eq, d_le, d_lt};
    endfunction

    function automatic logic [2:0] vld_vec();
        return {v_eq, v_le, v_lt};
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Signed integer key: the float's value order, with -0 and +0 both mapping to 0.
    function automatic longint fkey(input logic [31:0] x);
        longint k;
        k = longint'({33'd0, x[30:0]});
        return x[31] ? -k : k;
    endfunction

    function automatic logic ref_cmp(input int op, input logic [31:0] a, input logic [31:0] b);
        longint ka, kb;
        if (is_nan(a) || is_nan(b)) return 1'b0;
        ka = fkey(a);
        kb = fkey(b);
        case (op)
            0:       return ka == kb;
            1:       return ka <= kb;
            default: return ka < kb;
        endcase
    endfunction

    function automatic logic [23:0] exp_vec(input logic [31:0] a, input logic [31:0] b);
        return {7'd0, ref_cmp(0, a, b), 7'd0, ref_cmp(1, a, b), 7'd0, ref_cmp(2, a, b)};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] sp [10];
        sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
               32'h00000001, 32'h80000001, 32'h3F800000, 32'hBF800000, 32'h7F800001};
        if ($urandom_range(0, 1) == 0) return sp[$urandom_range(0, 9)];
        return 32'($urandom);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_a(input logic [31:0] d);
        int n;
        logic rdy;
        n = 0;
        a_data  = d;
        a_valid = 1'b1;
        do begin
            rdy = a_rdy_eq;
            tick();
            n++;
        end while (!rdy && n < 200);
        a_valid = 1'b0;
        check("push_a_timeout", 32'(n < 200), 32'd1);
    endtask

    task automatic push_b(input logic [31:0] d);
        int n;
        logic rdy;
        n = 0;
        b_data  = d;
        b_valid = 1'b1;
        do begin
            rdy = b_rdy_eq;
            tick();
            n++;
        end while (!rdy && n < 200);
        b_valid = 1'b0;
        check("push_b_timeout", 32'(n < 200), 32'd1);
    endtask

    // Present A and B together, measure latency from the accepting edge, and check the result.
    task automatic pair_lat(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [23:0] want);
        int n;
        exp_q.push_back(exp_vec(a, b));
        check({tag, "_rdy"}, 32'({a_rdy_eq, b_rdy_eq}), 32'h3);
        a_data  = a;
        b_data  = b;
        a_valid = 1'b1;
        b_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        n = 0;
        while (vld_vec() == 3'd0 && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(LAT));
        check({tag, "_data"}, 32'(obs_vec()), 32'(want));
        tick();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Output monitor: in-order results, stable data under backpressure, no spurious beats.
    always @(negedge CLK) begin
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_valid", 32'(vld_vec()), 32'h7);
                check("stall_data", 32'(obs_vec()), 32'(hold_d));
            end
            if (vld_vec() != 3'd0) begin
                check("valid_agree", 32'(vld_vec()), 32'h7);
                n_chk++;
                assert (exp_q.size() > 0) else begin
                    n_fail++;
                    $error("FAIL spurious_result: observed beat %h, expected no beat", obs_vec());
                end
                if (m_ready && exp_q.size() > 0) begin
                    check("result", 32'(obs_vec()), 32'(exp_q.pop_front()));
                end
                hold_v = !m_ready;
                hold_d = obs_vec();
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] ra [40];
        logic [31:0] rb [40];
        logic        done;
        reset   = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 32'h3F800000;
        b_data  = 32'h40000000;
        m_ready = 1'b1;
        tick();
        tick();
        reset   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("rst_a_rdy", 32'({a_rdy_eq, a_rdy_le, a_rdy_lt}), 32'h7);
        check("rst_b_rdy", 32'({b_rdy_eq, b_rdy_le, b_rdy_lt}), 32'h7);
        check("rst_valid", 32'(vld_vec()), 32'h0);
        check("rst_data", 32'(obs_vec()), 32'h0);

        // Directed pairs: {EQ, LE, LT} per byte.
        pair_lat("one_two",   32'h3F800000, 32'h40000000, 24'h000101);
        pair_lat("two_one",   32'h40000000, 32'h3F800000, 24'h000000);
        pair_lat("pz_nz",     32'h00000000, 32'h80000000, 24'h010100);
        pair_lat("qnan",      32'h7FC00000, 32'h7FC00000, 24'h000000);
        pair_lat("neg2_neg1", 32'hC0000000, 32'hBF800000, 24'h000101);
        pair_lat("inf_inf",   32'h7F800000, 32'h7F800000, 24'h010100);
        pair_lat("ninf_zero", 32'hFF800000, 32'h00000000, 24'h000101);
        pair_lat("dn_ndn",    32'h00000001, 32'h80000001, 24'h000000);

        // A three cycles ahead of B: A slot stays closed until the pair issues.
        exp_q.push_back(exp_vec(32'h3F800000, 32'hBF800000));
        push_a(32'h3F800000);
        for (int i = 0; i < 3; i++) begin
            check("skew_a_rdy", 32'(a_rdy_eq), 32'd0);
            check("skew_b_rdy", 32'(b_rdy_eq), 32'd1);
            tick();
        end
        push_b(32'hBF800000);
        tick();
        check("skew_rdy_after_issue", 32'({a_rdy_eq, b_rdy_eq}), 32'h3);
        drain("skew_drain");

        // Backpressure for 6 cycles with three pairs queued behind it.
        m_ready = 1'b0;
        exp_q.push_back(exp_vec(32'h40400000, 32'h40400000));
        exp_q.push_back(exp_vec(32'hC1200000, 32'h41200000));
        exp_q.push_back(exp_vec(32'h7F800001, 32'h00000000));
        fork
            begin
                push_a(32'h40400000);
                push_a(32'hC1200000);
                push_a(32'h7F800001);
            end
            begin
                push_b(32'h40400000);
                push_b(32'h41200000);
                push_b(32'h00000000);
            end
            begin
                repeat (6) tick();
                check("stall_a_rdy", 32'(a_rdy_eq), 32'd0);
                check("stall_b_rdy", 32'(b_rdy_eq), 32'd0);
                m_ready = 1'b1;
            end
        join
        drain("stall_drain");

        // Reset with the pipeline and both slots occupied.
        m_ready = 1'b0;
        exp_q.push_back(exp_vec(32'h3F800000, 32'h3F800000));
        exp_q.push_back(exp_vec(32'h3F800000, 32'h40000000));
        fork
            begin
                push_a(32'h3F800000);
                push_a(32'h3F800000);
            end
            begin
                push_b(32'h3F800000);
                push_b(32'h40000000);
            end
        join
        tick();
        check("pre_rst_full", 32'({a_rdy_eq, b_rdy_eq}), 32'h0);
        check("pre_rst_valid", 32'(vld_vec()), 32'h7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        check("post_rst_rdy", 32'({a_rdy_eq, b_rdy_eq, a_rdy_lt, b_rdy_lt}), 32'hF);
        check("post_rst_valid", 32'(vld_vec()), 32'h0);
        check("post_rst_data", 32'(obs_vec()), 32'h0);
        m_ready = 1'b1;
        repeat (6) tick();
        pair_lat("post_rst", 32'hBF800000, 32'h80000000, 24'h000101);

        // Randomized operands, arrival skew and backpressure.
        for (int i = 0; i < 40; i++) begin
            ra[i] = rand_fp();
            case ($urandom_range(0, 3))
                0:       rb[i] = ra[i];
                1:       rb[i] = {~ra[i][31], ra[i][30:0]};
                default: rb[i] = rand_fp();
            endcase
            exp_q.push_back(exp_vec(ra[i], rb[i]));
        end
        done = 1'b0;
        fork
            begin
                fork
                    for (int i = 0; i < 40; i++) begin
                        repeat ($urandom_range(0, 3)) tick();
                        push_a(ra[i]);
                    end
                    for (int j = 0; j < 40; j++) begin
                        repeat ($urandom_range(0, 3)) tick();
                        push_b(rb[j]);
                    end
                join
                done = 1'b1;
            end
            begin
                while (!done) begin
                    m_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                m_ready = 1'b1;
            end
        join
        drain("random_drain");
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fcmp_axis.md
FCMP_AXIS -- requirements
Module: fcmp_axis

Interface
REQ-001 SHALL have parameter OP, default 0; compare select: 0 = equal, 1 = less-or-equal, 2 = less-than (a op b).
REQ-002 SHALL have parameter LATENCY, default 2; number of pipeline stages after issue, legal range 1..4.
REQ-003 SHALL use clock CLK and reset reset, where reset is synchronous and active-high.
REQ-004 SHALL have these ports:
  CLK  input  1  clock
  reset  input  1  synchronous active-high reset
  s_axis_a_tdata  input  32  operand A, IEEE-754 single
  s_axis_a_tvalid  input  1  A valid
  s_axis_a_tready  output  1  A holding slot empty
  s_axis_b_tdata  input  32  operand B, IEEE-754 single
  s_axis_b_tvalid  input  1  B valid
  s_axis_b_tready  output  1  B holding slot empty
  m_axis_result_tdata  output  8  bit0 = compare result, bits 7:1 = 0
  m_axis_result_tvalid  output  1  result valid
  m_axis_result_tready  input  1  consumer accepts result

Function
REQ-005 SHALL transfer a beat on any channel only on a rising CLK edge where tvalid and tready are both 1.
REQ-006 SHALL provide one holding register per input channel, each with a full flag.
REQ-007 SHALL drive s_axis_x_tready = !full_x, taken directly from the flag, with no combinational path from any input.
REQ-008 SHALL set full_x and capture the tdata on an accepted beat; A and B are accepted independently and in any order.
REQ-009 SHALL define advance = !(m_axis_result_tvalid && !m_axis_result_tready); all stages shift together only when advance = 1.
REQ-010 SHALL issue the held pair into stage 1 on an edge where full_a && full_b && advance, clearing both full flags on that edge.
REQ-011 SHALL insert a bubble (stage-1 valid = 0) on an advancing edge with no issue.
REQ-012 SHALL compute the result combinationally from the held operands at issue; later stages carry the result and a valid bit unchanged.
REQ-013 SHALL drive m_axis_result_tvalid and tdata from stage LATENCY, holding both stable while tvalid=1 and tready=0.
REQ-014 SHALL, with no stall, raise result tvalid in the cycle after the edge k+LATENCY, where edge k accepts the later of the A/B beats.
REQ-015 SHALL sustain a throughput of at most one result per 2 cycles, because a holding slot re-opens only the cycle after issue.
REQ-016 SHALL treat an operand as NaN when exp=0xFF and mantissa!=0; any NaN operand gives result 0 for all OP values.
REQ-017 SHALL treat +0 and -0 as equal: EQ=1, LE=1, LT=0.
REQ-018 SHALL order non-NaN operands by sign-magnitude compare of the 32-bit values, with denormals and infinities compared as encoded (no flush to zero).
REQ-019 SHALL give EQ=1 iff the encodings are identical or both operands are zero.
REQ-020 SHALL, when an input beat and an issue land on the same edge for the same channel, perform the issue only; a slot that is full never accepts.
REQ-021 SHALL keep the pipeline frozen and lose no data when a stall lasts any number of cycles.

Reset
REQ-022 SHALL, while reset=1 at an edge, clear full_a, full_b, all stage valid bits and all stage data to 0, regardless of any transfer in progress.
REQ-023 SHALL, after that reset edge, drive s_axis_a_tready=1, s_axis_b_tready=1, m_axis_result_tvalid=0 and m_axis_result_tdata=0x00.
REQ-024 SHALL ignore all input tvalid during reset cycles.

Verification
REQ-025 OP=2, LATENCY=2; A=0x3F800000 and B=0x40000000 presented on the same edge k -> tdata=0x01, tvalid high in the cycle after edge k+2; swapped operands -> 0x00.
REQ-026 OP=0; A=0x00000000, B=0x80000000 -> 0x01. OP=2 with the same pair -> 0x00. OP=1 with A=0x7FC00000, B=0x7FC00000 -> 0x00.
REQ-027 OP=1; A=0xC0000000 (-2.0), B=0xBF800000 (-1.0) -> 0x01. A=0x7F800000, B=0x7F800000 -> 0x01.
REQ-028 A arrives 3 cycles before B -> s_axis_a_tready=0 for those cycles; one result only; both treadys return to 1 the cycle after issue.
REQ-029 Hold result tready=0 for 6 cycles with 3 pairs queued -> tvalid and tdata stay stable, input treadys drop, results emerge in order with none lost or duplicated.
REQ-030 Assert reset for 1 cycle with the pipeline and both slots full -> next cycle both treadys=1, tvalid=0, and no stale result ever appears.
